watch_counter: RTL and testbench
================================

Name: watch_counter

Overview:
- Time-of-day / stopwatch counter core. It sits directly downstream of the tick generator and consumes its single-cycle tick (default 100 Hz, i.e. 10 ms resolution).
- Accumulates ticks into centiseconds, seconds, minutes and hours, with run/stop control, clear, and manual per-field set.
- Outputs feed the display/FND mux and the UART report path.

Parameters:
- CSEC_MAX, 100, ticks per second; centisecond field wraps at CSEC_MAX-1.
- SEC_MAX, 60, seconds per minute.
- MIN_MAX, 60, minutes per hour.
- HOUR_MAX, 24, hours per day.
- HOUR_INIT, 0, hour value loaded on reset and on clear (0..HOUR_MAX-1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_tick  input  1  one-clk-wide tick from the upstream tick generator.
- i_run_stop  input  1  one-clk pulse; toggles STOP<->RUN.
- i_clear  input  1  one-clk pulse; zeroes the time and forces STOP.
- i_inc_sec  input  1  one-clk pulse; +1 second, honoured only in STOP.
- i_inc_min  input  1  one-clk pulse; +1 minute, honoured only in STOP.
- i_inc_hour  input  1  one-clk pulse; +1 hour, honoured only in STOP.
- o_csec  output  7  centiseconds 0..CSEC_MAX-1.
- o_sec  output  6  seconds 0..SEC_MAX-1.
- o_min  output  6  minutes 0..MIN_MAX-1.
- o_hour  output  5  hours 0..HOUR_MAX-1.
- o_running  output  1  1 while in RUN.
- o_day_tick  output  1  one-clk pulse on the hour wrap HOUR_MAX-1 -> 0 caused by counting.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = STOP.
  - o_csec=0, o_sec=0, o_min=0, o_hour=HOUR_INIT.
  - o_running=0, o_day_tick=0.
- Field widths are fixed as listed. Parameters must fit those widths; an out-of-range parameter is a configuration error and is not checked.
- All outputs are registered. An event sampled on clk edge N is visible on the outputs after edge N.
- FSM has two states:
  - STOP -> RUN on i_run_stop.
  - RUN -> STOP on i_run_stop.
  - Any state -> STOP on i_clear.
  - o_running = (state==RUN), registered together with the state.
- Priority within one cycle: i_clear > i_run_stop > i_tick / i_inc_*.
  - i_clear: csec/sec/min = 0, hour = HOUR_INIT, state = STOP. Any tick or inc in the same cycle is discarded.
  - i_run_stop + i_tick in the same cycle: the tick is processed according to the state before the toggle. A RUN->STOP toggle still counts that tick; a STOP->RUN toggle does not count it.
- Counting (RUN and i_tick=1): the cascade resolves in a single edge.
  - csec increments.
  - At csec=CSEC_MAX-1: csec->0 and sec increments.
  - At sec=SEC_MAX-1 with a csec carry: sec->0 and min increments.
  - The same rule applies min->hour.
  - At hour=HOUR_MAX-1 with a min carry: hour->0 and o_day_tick=1 for exactly one clk.
- i_tick in STOP: ignored.
- Set (STOP only):
  - Each i_inc_* increments its field by 1, wrapping at its MAX to 0.
  - No carry into higher fields; csec is unchanged.
  - No o_day_tick is generated.
  - Multiple i_inc_* in the same cycle each apply independently.
- i_inc_* in RUN: ignored.
- Reset mid-count: all fields return immediately to their reset values; the next tick after release is ignored until i_run_stop.
- Back-to-back ticks (tick every clk, upstream COUNT=0) are counted one per clk, with no loss.

Optional Feature:
- Macro: WATCH_COUNTER_ALARM_EN.
- With the macro defined, extra ports are added:
  - i_alarm_min (input, 6), i_alarm_hour (input, 5), i_alarm_arm (input, 1, level).
  - o_alarm (output, 1).
- o_alarm pulses for one clk when all of the following hold:
  - i_alarm_arm=1;
  - a counting edge moves the time to exactly hour=i_alarm_hour, min=i_alarm_min, sec=0, csec=0.
- Manual set does not trigger the alarm. o_alarm resets to 0.
- Without the macro: these ports do not exist and no alarm logic is synthesised.

Test Plan:
- Reset, then release; pulse i_run_stop; apply 250 ticks -> o_csec=50, o_sec=2, o_min=0, o_running=1.
- Clock preloaded via i_inc_* in STOP to 23:59:59 with csec=99; run, 1 tick -> all fields 0 and o_day_tick high for exactly 1 clk.
- In STOP, 61 i_inc_sec pulses -> o_sec=1 and o_min unchanged. In RUN, i_inc_min -> no change.
- i_clear asserted in the same cycle as i_tick while running at 00:00:05.37 -> o_csec/o_sec/o_min=0, o_hour=HOUR_INIT, o_running=0.
- i_run_stop and i_tick in the same cycle while running at csec=10 -> csec=11 and STOP; a later tick leaves csec=11.
- rst pulled low mid-count (asynchronous, between edges) -> outputs go to reset values before the next clk edge. With WATCH_COUNTER_ALARM_EN defined, arm=1, alarm 00:01, run 6000 ticks -> o_alarm pulses once.

Source files
------------

// File: rtl/watch_counter.sv
// Time-of-day / stopwatch counter: ticks -> csec/sec/min/hour with run/stop, clear and manual set.
// Latency: one clk, every event sampled on an edge is visible on the outputs right after that edge.
// No backpressure: every tick is consumed; optional alarm enabled by WATCH_COUNTER_ALARM_EN.
module watch_counter #(
   parameter int CSEC_MAX  = 100,
   parameter int SEC_MAX   = 60,
   parameter int MIN_MAX   = 60,
   parameter int HOUR_MAX  = 24,
   parameter int HOUR_INIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_run_stop,
   input  logic       i_clear,
   input  logic       i_inc_sec,
   input  logic       i_inc_min,
   input  logic       i_inc_hour,
`ifdef WATCH_COUNTER_ALARM_EN
   input  logic [5:0] i_alarm_min,
   input  logic [4:0] i_alarm_hour,
   input  logic       i_alarm_arm,
   output logic       o_alarm,
`endif
   output logic [6:0] o_csec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_running,
   output logic       o_day_tick
);

   typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [6:0] CSEC_LAST = 7'(CSEC_MAX - 1);
   localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
   localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
   localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);
   localparam logic [4:0] HOUR_RST  = 5'(HOUR_INIT);

   state_t     r_state, w_state_nxt;
   logic [6:0] r_csec, w_csec_nxt;
   logic [5:0] r_sec, w_sec_nxt;
   logic [5:0] r_min, w_min_nxt;
   logic [4:0] r_hour, w_hour_nxt;
   logic       r_day_tick, w_day_tick_nxt;
   logic       w_count;

   // A tick only counts when not cleared and the pre-toggle state is RUN.
   assign w_count = !i_clear && (r_state == ST_RUN) && i_tick;

   // Next-state: clear wins, run/stop toggles, counting cascade in RUN, per-field set in STOP.
   always_comb begin
      w_state_nxt    = r_state;
      w_csec_nxt     = r_csec;
      w_sec_nxt      = r_sec;
      w_min_nxt      = r_min;
      w_hour_nxt     = r_hour;
      w_day_tick_nxt = 1'b0;
      if (i_clear) begin
         w_state_nxt = ST_STOP;
         w_csec_nxt  = '0;
         w_sec_nxt   = '0;
         w_min_nxt   = '0;
         w_hour_nxt  = HOUR_RST;
      end else begin
         if (i_run_stop) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
         end
         if (r_state == ST_RUN) begin
            if (i_tick) begin
               if (r_csec == CSEC_LAST) begin
                  w_csec_nxt = '0;
                  if (r_sec == SEC_LAST) begin
                     w_sec_nxt = '0;
                     if (r_min == MIN_LAST) begin
                        w_min_nxt = '0;
                        if (r_hour == HOUR_LAST) begin
                           w_hour_nxt     = '0;
                           w_day_tick_nxt = 1'b1;
                        end else begin
                           w_hour_nxt = r_hour + 5'd1;
                        end
                     end else begin
                        w_min_nxt = r_min + 6'd1;
                     end
                  end else begin
                     w_sec_nxt = r_sec + 6'd1;
                  end
               end else begin
                  w_csec_nxt = r_csec + 7'd1;
               end
            end
         end else begin
            // Manual set: each field wraps on its own, no carry, no day tick.
            if (i_inc_sec) begin
               w_sec_nxt = (r_sec == SEC_LAST) ? 6'd0 : r_sec + 6'd1;
            end
            if (i_inc_min) begin
               w_min_nxt = (r_min == MIN_LAST) ? 6'd0 : r_min + 6'd1;
            end
            if (i_inc_hour) begin
               w_hour_nxt = (r_hour == HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
            end
         end
      end
   end

   // State and time registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_STOP;
         r_csec     <= '0;
         r_sec      <= '0;
         r_min      <= '0;
         r_hour     <= HOUR_RST;
         r_day_tick <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_csec     <= w_csec_nxt;
         r_sec      <= w_sec_nxt;
         r_min      <= w_min_nxt;
         r_hour     <= w_hour_nxt;
         r_day_tick <= w_day_tick_nxt;
      end
   end

`ifdef WATCH_COUNTER_ALARM_EN
   logic r_alarm, w_alarm_nxt;

   // Alarm fires only when a counting edge lands exactly on hh:mm:00.00.
   always_comb begin
      w_alarm_nxt = i_alarm_arm && w_count
                    && (w_hour_nxt == i_alarm_hour) && (w_min_nxt == i_alarm_min)
                    && (w_sec_nxt == 6'd0) && (w_csec_nxt == 7'd0);
   end

   // Alarm pulse register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alarm <= 1'b0;
      end else begin
         r_alarm <= w_alarm_nxt;
      end
   end

   assign o_alarm = r_alarm;
`else
   logic w_count_unused;
   assign w_count_unused = w_count;
`endif

   assign o_csec     = r_csec;
   assign o_sec      = r_sec;
   assign o_min      = r_min;
   assign o_hour     = r_hour;
   assign o_running  = (r_state == ST_RUN);
   assign o_day_tick = r_day_tick;

endmodule

// File: tb/tb_watch_counter.sv
// Directed testbench for watch_counter.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Alarm scenario is compiled only when WATCH_COUNTER_ALARM_EN is defined.
module tb_watch_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_tick = 1'b0, i_run_stop = 1'b0, i_clear = 1'b0;
   logic       i_inc_sec = 1'b0, i_inc_min = 1'b0, i_inc_hour = 1'b0;
   logic [6:0] o_csec;
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hour;
   logic       o_running, o_day_tick;
`ifdef WATCH_COUNTER_ALARM_EN
   logic [5:0] i_alarm_min = 6'd0;
   logic [4:0] i_alarm_hour = 5'd0;
   logic       i_alarm_arm = 1'b0;
   logic       o_alarm;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   watch_counter dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_run_stop(i_run_stop), .i_clear(i_clear),
      .i_inc_sec(i_inc_sec), .i_inc_min(i_inc_min), .i_inc_hour(i_inc_hour),
`ifdef WATCH_COUNTER_ALARM_EN
      .i_alarm_min(i_alarm_min), .i_alarm_hour(i_alarm_hour), .i_alarm_arm(i_alarm_arm),
      .o_alarm(o_alarm),
`endif
      .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
      .o_running(o_running), .o_day_tick(o_day_tick)
   );

   // One clock cycle with the given input pulses; returns 1 unit after the edge.
   task automatic cyc(input logic t, input logic rs, input logic cl,
                      input logic is, input logic im, input logic ih);
      i_tick = t; i_run_stop = rs; i_clear = cl;
      i_inc_sec = is; i_inc_min = im; i_inc_hour = ih;
      @(posedge clk); #1;
      i_tick = 0; i_run_stop = 0; i_clear = 0;
      i_inc_sec = 0; i_inc_min = 0; i_inc_hour = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({o_csec, o_sec, o_min, o_hour, o_running, o_day_tick} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_state got %0d:%0d:%0d.%0d run=%0b day=%0b exp 0:0:0.0 run=0 day=0",
                  o_hour, o_min, o_sec, o_csec, o_running, o_day_tick);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      // tick while stopped after release is ignored
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_csec !== 7'd0 || o_running !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_tick_ignored got csec=%0d run=%0b exp csec=0 run=0", o_csec, o_running);
      end
   endtask

   task automatic test_run_count;
      cyc(0, 1, 0, 0, 0, 0);
      n_checks++;
      if (o_running !== 1'b1) begin
         n_fail++;
         $display("FAIL run_toggle got run=%0b exp 1", o_running);
      end
      ticks(250);
      n_checks++;
      if (o_csec !== 7'd50 || o_sec !== 6'd2 || o_min !== 6'd0 || o_running !== 1'b1) begin
         n_fail++;
         $display("FAIL run_250 got %0d:%0d.%0d run=%0b exp 0:2.50 run=1", o_min, o_sec, o_csec, o_running);
      end
   endtask

   task automatic test_inc_sec;
      cyc(0, 0, 1, 0, 0, 0);
      n_checks++;
      if ({o_csec, o_sec, o_min, o_hour, o_running} !== 25'd0) begin
         n_fail++;
         $display("FAIL clear_state got %0d:%0d:%0d.%0d run=%0b exp 0:0:0.0 run=0",
                  o_hour, o_min, o_sec, o_csec, o_running);
      end
      for (int i = 0; i < 61; i++) cyc(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (o_sec !== 6'd1 || o_min !== 6'd0 || o_csec !== 7'd0) begin
         n_fail++;
         $display("FAIL inc_sec_61 got min=%0d sec=%0d csec=%0d exp 0 1 0", o_min, o_sec, o_csec);
      end
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (o_min !== 6'd0 || o_sec !== 6'd1 || o_running !== 1'b1) begin
         n_fail++;
         $display("FAIL inc_min_in_run got min=%0d sec=%0d run=%0b exp 0 1 1", o_min, o_sec, o_running);
      end
   endtask

   task automatic test_day_wrap;
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(99);
      cyc(0, 1, 0, 0, 0, 0);
      // simultaneous incs apply independently: 23 of all three, then 36 of min+sec
      for (int i = 0; i < 23; i++) cyc(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 36; i++) cyc(0, 0, 0, 1, 1, 0);
      n_checks++;
      if (o_hour !== 5'd23 || o_min !== 6'd59 || o_sec !== 6'd59 || o_csec !== 7'd99 || o_running !== 1'b0) begin
         n_fail++;
         $display("FAIL preload got %0d:%0d:%0d.%0d run=%0b exp 23:59:59.99 run=0",
                  o_hour, o_min, o_sec, o_csec, o_running);
      end
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_csec} !== 24'd0 || o_day_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL day_wrap got %0d:%0d:%0d.%0d day=%0b exp 0:0:0.0 day=1",
                  o_hour, o_min, o_sec, o_csec, o_day_tick);
      end
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_day_tick !== 1'b0 || o_csec !== 7'd1) begin
         n_fail++;
         $display("FAIL day_tick_width got day=%0b csec=%0d exp day=0 csec=1", o_day_tick, o_csec);
      end
      // manual hour wrap 23->0 must not raise day tick
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 23; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      n_checks++;
      if (o_hour !== 5'd0 || o_day_tick !== 1'b0 || o_min !== 6'd0) begin
         n_fail++;
         $display("FAIL set_hour_wrap got hour=%0d min=%0d day=%0b exp 0 0 0", o_hour, o_min, o_day_tick);
      end
   endtask

   task automatic test_clear_tick;
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(537);
      n_checks++;
      if (o_sec !== 6'd5 || o_csec !== 7'd37 || o_min !== 6'd0) begin
         n_fail++;
         $display("FAIL count_537 got %0d:%0d.%0d exp 0:5.37", o_min, o_sec, o_csec);
      end
      cyc(1, 0, 1, 0, 0, 0);
      n_checks++;
      if ({o_csec, o_sec, o_min, o_hour, o_running} !== 25'd0) begin
         n_fail++;
         $display("FAIL clear_with_tick got %0d:%0d:%0d.%0d run=%0b exp 0:0:0.0 run=0",
                  o_hour, o_min, o_sec, o_csec, o_running);
      end
   endtask

   task automatic test_runstop_tick;
      cyc(0, 1, 0, 0, 0, 0);
      ticks(10);
      cyc(1, 1, 0, 0, 0, 0);
      n_checks++;
      if (o_csec !== 7'd11 || o_running !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_with_tick got csec=%0d run=%0b exp 11 0", o_csec, o_running);
      end
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_csec !== 7'd11) begin
         n_fail++;
         $display("FAIL tick_after_stop got csec=%0d exp 11", o_csec);
      end
      cyc(1, 1, 0, 0, 0, 0);
      n_checks++;
      if (o_csec !== 7'd11 || o_running !== 1'b1) begin
         n_fail++;
         $display("FAIL start_with_tick got csec=%0d run=%0b exp 11 1", o_csec, o_running);
      end
   endtask

   task automatic test_async_reset;
      ticks(300);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({o_csec, o_sec, o_min, o_hour, o_running, o_day_tick} !== 26'd0) begin
         n_fail++;
         $display("FAIL async_reset got %0d:%0d:%0d.%0d run=%0b exp 0:0:0.0 run=0",
                  o_hour, o_min, o_sec, o_csec, o_running);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_csec !== 7'd0 || o_running !== 1'b0) begin
         n_fail++;
         $display("FAIL tick_after_reset got csec=%0d run=%0b exp 0 0", o_csec, o_running);
      end
   endtask

`ifdef WATCH_COUNTER_ALARM_EN
   task automatic test_alarm;
      int pulses;
      int at;
      pulses = 0;
      at = -1;
      i_alarm_arm = 1'b1; i_alarm_hour = 5'd0; i_alarm_min = 6'd1;
      cyc(0, 0, 1, 0, 0, 0);
      n_checks++;
      if (o_alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_idle got %0b exp 0", o_alarm);
      end
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 6100; i++) begin
         cyc(1, 0, 0, 0, 0, 0);
         if (o_alarm === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      n_checks++;
      if (pulses != 1 || at != 6000) begin
         n_fail++;
         $display("FAIL alarm_pulse got pulses=%0d at_tick=%0d exp 1 at 6000", pulses, at);
      end
      i_alarm_arm = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_run_count();
      test_inc_sec();
      test_day_wrap();
      test_clear_tick();
      test_runstop_tick();
      test_async_reset();
`ifdef WATCH_COUNTER_ALARM_EN
      test_alarm();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
